// File: rtl/pixel_frame_serializer.sv
// Pixel frame serializer: captures an H x W frame of 8-bit pixels in one cycle
// and streams it out one pixel per accepted handshake, with row/col tags and
// start/end-of-frame markers. Frames arriving mid-transfer are counted as drops.
module pixel_frame_serializer #(
  parameter int H  = 4,
  parameter int W  = 4,
  parameter int N  = H*W,
  localparam int RW = (H > 1) ? $clog2(H) : 1,
  localparam int CW = (W > 1) ? $clog2(W) : 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N*8-1:0] frame_data,
  input  logic           frame_valid,
  output logic [7:0]     pix_data,
  output logic           pix_valid,
  input  logic           pix_ready,
  output logic [RW-1:0]  pix_row,
  output logic [CW-1:0]  pix_col,
  output logic           pix_sof,
  output logic           pix_eof,
  output logic           busy,
  output logic [7:0]     drop_count
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, SEND} state_t;

  state_t             state, state_nx;
  logic [N-1:0][7:0]  pix_buf;
  logic [IW-1:0]      idx, idx_nx;
  logic               xfer, last, capture, drop;

  assign xfer = (state == SEND) && pix_ready;
  assign last = (idx == IW'(N-1));

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Next state, pixel index, capture and drop decisions
  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    capture  = 1'b0;
    drop     = 1'b0;
    case (state)
      IDLE: begin
        if (frame_valid) begin
          capture  = 1'b1;
          idx_nx   = '0;
          state_nx = SEND;
        end
      end
      SEND: begin
        if (xfer && last) begin
          // A frame landing exactly on the eof transfer chains on with no bubble
          idx_nx = '0;
          if (frame_valid) capture  = 1'b1;
          else             state_nx = IDLE;
        end else begin
          if (xfer)        idx_nx = idx + 1'b1;
          if (frame_valid) drop   = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Frame buffer, pixel index and saturating drop counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pix_buf    <= '0;
      idx        <= '0;
      drop_count <= '0;
    end else begin
      idx <= idx_nx;
      if (capture) pix_buf <= frame_data;
      if (drop && (drop_count != 8'hFF)) drop_count <= drop_count + 8'd1;
    end
  end

  // Outputs derive from registered state only, so they hold while stalled
  // and drop to zero the instant reset clears the registers.
  assign pix_valid = (state == SEND);
  assign busy      = pix_valid;
  assign pix_data  = pix_valid ? pix_buf[idx] : 8'h00;
  assign pix_row   = pix_valid ? RW'(32'(idx) / W) : '0;
  assign pix_col   = pix_valid ? CW'(32'(idx) % W) : '0;
  assign pix_sof   = pix_valid && (idx == '0);
  assign pix_eof   = pix_valid && last;

endmodule

// File: tb/tb_pixel_frame_serializer.sv
// Directed bench for pixel_frame_serializer (H=W=4): streaming, stalls,
// drops and saturation, back-to-back frames, async reset mid-frame.
module tb_pixel_frame_serializer;

  localparam int H = 4;
  localparam int W = 4;
  localparam int N = 16;

  logic           clk;
  logic           reset;
  logic [N*8-1:0] frame_data;
  logic           frame_valid;
  logic [7:0]     pix_data;
  logic           pix_valid;
  logic           pix_ready;
  logic [1:0]     pix_row;
  logic [1:0]     pix_col;
  logic           pix_sof;
  logic           pix_eof;
  logic           busy;
  logic [7:0]     drop_count;

  int checks = 0;
  int errors = 0;

  pixel_frame_serializer #(.H(H), .W(W), .N(N)) dut (
    .clk(clk), .reset(reset), .frame_data(frame_data), .frame_valid(frame_valid),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_row(pix_row), .pix_col(pix_col), .pix_sof(pix_sof), .pix_eof(pix_eof),
    .busy(busy), .drop_count(drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pixel p of the frame gets value base+p
  task automatic load(input logic [7:0] base);
    for (int p = 0; p < N; p++) frame_data[p*8 +: 8] = base + 8'(p);
  endtask

  // Expected view of a frame in SEND at pixel index i
  task automatic check_pix(input string tag, input int i, input logic [7:0] exp_data);
    check($sformatf("%s_valid[%0d]", tag, i), 32'(pix_valid), 32'd1);
    check($sformatf("%s_busy[%0d]",  tag, i), 32'(busy),      32'd1);
    check($sformatf("%s_data[%0d]",  tag, i), 32'(pix_data),  32'(exp_data));
    check($sformatf("%s_row[%0d]",   tag, i), 32'(pix_row),   32'(i / W));
    check($sformatf("%s_col[%0d]",   tag, i), 32'(pix_col),   32'(i % W));
    check($sformatf("%s_sof[%0d]",   tag, i), 32'(pix_sof),   32'(i == 0));
    check($sformatf("%s_eof[%0d]",   tag, i), 32'(pix_eof),   32'(i == N-1));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, 32'(pix_valid),  32'd0);
    check({tag, "_data"},  32'(pix_data),   32'd0);
    check({tag, "_row"},   32'(pix_row),    32'd0);
    check({tag, "_col"},   32'(pix_col),    32'd0);
    check({tag, "_sof"},   32'(pix_sof),    32'd0);
    check({tag, "_eof"},   32'(pix_eof),    32'd0);
    check({tag, "_busy"},  32'(busy),       32'd0);
    check({tag, "_drop"},  32'(drop_count), 32'd0);
  endtask

  initial begin
    logic [3:0] pat;
    int k;
    int cyc;
    pat = 4'b1001;   // ready sequence 1,0,0,1 (bit 0 first)
    reset = 1'b0; frame_valid = 1'b0; pix_ready = 1'b0; frame_data = '0;
    #12;
    check_zero("rst");
    @(negedge clk); reset = 1'b1;

    // Full-throughput frame; frame_data scrambled after capture
    @(negedge clk); load(8'd1); frame_valid = 1'b1; pix_ready = 1'b1;
    @(negedge clk); frame_valid = 1'b0; frame_data = {N{8'hAA}};
    for (int i = 0; i < N; i++) begin
      check_pix("t1", i, 8'(i + 1));
      @(negedge clk);
    end
    check("t1_end_valid", 32'(pix_valid), 32'd0);
    check("t1_end_busy",  32'(busy),      32'd0);

    // Stalls with ready pattern 1,0,0,1
    @(negedge clk); load(8'd1); frame_valid = 1'b1; pix_ready = 1'b0;
    @(negedge clk); frame_valid = 1'b0;
    k = 0; cyc = 0;
    while (k < N && cyc < 200) begin
      pix_ready = pat[cyc % 4];
      check_pix("t2", k, 8'(k + 1));
      if (pix_ready) k++;
      cyc++;
      @(negedge clk);
    end
    check("t2_done",      32'(k),         32'(N));
    check("t2_end_valid", 32'(pix_valid), 32'd0);
    pix_ready = 1'b1;

    // frame_valid at pixel index 5 is dropped; frame A unchanged
    @(negedge clk); load(8'd1); frame_valid = 1'b1;
    @(negedge clk); frame_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      check_pix("t3", i, 8'(i + 1));
      if (i == 5) begin frame_valid = 1'b1; load(8'h80); end
      else frame_valid = 1'b0;
      @(negedge clk);
    end
    check("t3_end_valid", 32'(pix_valid),  32'd0);
    check("t3_drop",      32'(drop_count), 32'd1);

    // Frame B arrives with frame A eof transfer: no bubble, no drop
    @(negedge clk); load(8'd1); frame_valid = 1'b1;
    @(negedge clk); frame_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      check_pix("t4a", i, 8'(i + 1));
      if (i == N-1) begin frame_valid = 1'b1; load(8'h40); end
      @(negedge clk);
    end
    frame_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      check_pix("t4b", i, 8'(8'h40 + i));
      @(negedge clk);
    end
    check("t4_end_valid", 32'(pix_valid),  32'd0);
    check("t4_drop",      32'(drop_count), 32'd1);

    // 300 drops while stalled at pixel 0: counter saturates at 255
    @(negedge clk); load(8'd1); frame_valid = 1'b1; pix_ready = 1'b0;
    @(negedge clk); load(8'h20);
    repeat (300) @(negedge clk);
    frame_valid = 1'b0;
    check("t5_drop_sat", 32'(drop_count), 32'd255);
    check("t5_hold",     32'(pix_data),   32'd1);
    @(negedge clk); pix_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      check_pix("t5", i, 8'(i + 1));
      @(negedge clk);
    end
    check("t5_end_valid", 32'(pix_valid),  32'd0);
    check("t5_drop_end",  32'(drop_count), 32'd255);

    // Async reset at pixel index 7 clears everything before the next edge
    @(negedge clk); load(8'd1); frame_valid = 1'b1;
    @(negedge clk); frame_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check_pix("t6", i, 8'(i + 1));
      if (i < 7) @(negedge clk);
    end
    #1 reset = 1'b0;
    #1 check_zero("t6_rst");
    @(negedge clk); reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("t6_post_valid", 32'(pix_valid), 32'd0);
      check("t6_post_busy",  32'(busy),      32'd0);
    end

    // frame_valid coincident with reset release is captured
    reset = 1'b0;
    @(negedge clk); reset = 1'b1; load(8'd1); frame_valid = 1'b1;
    @(negedge clk); frame_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      check_pix("t7", i, 8'(i + 1));
      @(negedge clk);
    end
    check("t7_end_valid", 32'(pix_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pixel_frame_serializer.md
PIXEL_FRAME_SERIALIZER -- requirements
Module: pixel_frame_serializer

Interface
REQ-001 Parameter H, default 4, pixel array rows.
REQ-002 Parameter W, default 4, pixel array columns.
REQ-003 Parameter N, default 16, total pixels; SHALL equal H*W.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset; asserting it (0) clears state immediately, deassertion sampled on clk.
REQ-006 frame_data  input  N*8  binary pixel frame; pixel p (p = row*W + col) at bits [8p+7:8p].
REQ-007 frame_valid  input  1  one-cycle pulse; frame_data is complete and stable this cycle.
REQ-008 pix_data  output  8  current pixel value.
REQ-009 pix_valid  output  1  pix_data/pix_row/pix_col/pix_sof/pix_eof valid.
REQ-010 pix_ready  input  1  downstream accepts pixel when high with pix_valid.
REQ-011 pix_row  output  max(1,ceil(log2(H)))  row index of current pixel.
REQ-012 pix_col  output  max(1,ceil(log2(W)))  column index of current pixel.
REQ-013 pix_sof  output  1  high with pixel 0 of a frame.
REQ-014 pix_eof  output  1  high with pixel N-1 of a frame.
REQ-015 busy  output  1  high while a captured frame is not fully transferred.
REQ-016 drop_count  output  8  count of frames discarded, saturating.

Function
REQ-017 States SHALL be IDLE and SEND only.
REQ-018 IDLE + frame_valid: capture frame_data into an internal N*8 buffer, pixel index := 0, go to SEND next cycle.
REQ-019 SEND: pix_valid = 1, pix_data = buffer pixel at index, pix_row = index / W, pix_col = index mod W.
REQ-020 Transfer occurs on a cycle with pix_valid && pix_ready; index then increments by 1 (column wraps to 0 and row increments at col W-1).
REQ-021 Without pix_ready, all pix_* outputs SHALL hold unchanged (no data change while valid and stalled).
REQ-022 pix_sof = 1 exactly when index = 0 in SEND; pix_eof = 1 exactly when index = N-1 in SEND.
REQ-023 Transfer at index N-1 with no frame_valid in that cycle: return to IDLE, pix_valid = 0 next cycle.
REQ-024 Transfer at index N-1 with frame_valid in the same cycle: capture new frame, index := 0, remain in SEND; no bubble cycle; not a drop.
REQ-025 frame_valid in SEND other than REQ-024 case: new frame discarded, buffer untouched, drop_count += 1.
REQ-026 drop_count SHALL saturate at 255 and never wrap.
REQ-027 Latency: first pixel pix_valid SHALL rise the cycle after frame_valid capture in IDLE.
REQ-028 Full-throughput frame (pix_ready held 1) SHALL take exactly N cycles of pix_valid.
REQ-029 busy = 1 in SEND, 0 in IDLE.
REQ-030 frame_data is sampled only on the capture cycle; later changes SHALL not affect output.

Reset
REQ-031 reset = 0 SHALL asynchronously force IDLE, index 0, buffer 0, drop_count 0, pix_data 0, pix_valid 0, pix_sof 0, pix_eof 0, pix_row 0, pix_col 0, busy 0.
REQ-032 Reset mid-frame SHALL abandon the frame; no pixel of it SHALL appear after release.
REQ-033 frame_valid in the cycle reset is released SHALL be captured normally per REQ-018 once reset reads 1 at that edge.

Verification
REQ-034 H=W=4; frame_data pixel p = p+1, frame_valid pulse, pix_ready=1 -> 16 consecutive pix_valid cycles, pix_data 1..16, row/col (0,0)..(3,3), sof with 1, eof with 16, busy falls after.
REQ-035 Same frame, pix_ready toggling 1,0,0,1 pattern -> outputs frozen during 0 cycles, same 16-value sequence, no duplicates or skips.
REQ-036 frame_valid at pixel index 5 of frame A -> drop_count = 1, frame A completes unchanged; 300 such drops -> drop_count = 255.
REQ-037 frame B frame_valid coincident with frame A eof transfer -> next cycle pix_sof = 1 with B pixel 0, drop_count unchanged, pix_valid never deasserts.
REQ-038 reset = 0 asserted at pixel index 7 -> all outputs 0 immediately (before next clk edge); after release pix_valid stays 0 until next frame_valid.
